// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and branch-operand stall control with a
// cumulative stall counter and a sticky watchdog for runaway stall chains.
module hazard_unit #(
    parameter int unsigned WDOG_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_branch,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    output logic        hazard,
    output logic        BranchBubble,
    output logic        idex_flush,
    output logic [31:0] stall_cnt,
    output logic        deadlock_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        BR_WAIT2 = 2'd2,
        BR_WAIT1 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [3:0]  consec_q, consec_d;
    logic        deadlock_err_q, deadlock_err_d;

    logic ex_match;
    logic mem_match;
    logic stall;

    // Source-operand matches against EX and MEM destinations; r0 never matches.
    always_comb begin
        ex_match  = (ex_rd != 5'd0) &&
                    ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
        mem_match = (mem_rd != 5'd0) &&
                    ((id_use_rs && (mem_rd == id_rs)) || (id_use_rt && (mem_rd == id_rt)));
    end

    // Next-state and stall decode; detection only happens from IDLE, reset forces outputs low.
    always_comb begin
        state_d      = state_q;
        hazard       = 1'b0;
        BranchBubble = 1'b0;
        idex_flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_branch && ex_memread && ex_match) begin
                    // Branch needs a value still being loaded: two freezes then a bubble.
                    hazard     = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = BR_WAIT2;
                end else if (!id_branch && ex_memread && ex_match) begin
                    hazard     = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = LD_STALL;
                end else if (id_branch && ex_regwrite && !ex_memread && ex_match) begin
                    BranchBubble = 1'b1;
                    idex_flush   = 1'b1;
                    state_d      = BR_WAIT1;
                end else if (id_branch && mem_memread && mem_match) begin
                    BranchBubble = 1'b1;
                    idex_flush   = 1'b1;
                    state_d      = BR_WAIT1;
                end
            end
            LD_STALL: begin
                // Load has reached MEM and is forwarded from there.
                state_d = IDLE;
            end
            BR_WAIT2: begin
                hazard     = 1'b1;
                idex_flush = 1'b1;
                state_d    = BR_WAIT1;
            end
            BR_WAIT1: begin
                BranchBubble = 1'b1;
                idex_flush   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            hazard       = 1'b0;
            BranchBubble = 1'b0;
            idex_flush   = 1'b0;
            state_d      = IDLE;
        end
    end

    // Stall accounting: wrapping total, saturating consecutive count, sticky watchdog.
    always_comb begin
        stall          = hazard | BranchBubble;
        stall_cnt_d    = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
        consec_d       = 4'd0;
        if (stall) begin
            consec_d = (consec_q == 4'hF) ? 4'hF : (consec_q + 4'd1);
        end
        deadlock_err_d = deadlock_err_q | (32'(consec_d) >= WDOG_LIMIT);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            stall_cnt_q    <= 32'd0;
            consec_q       <= 4'd0;
            deadlock_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            consec_q       <= consec_d;
            deadlock_err_q <= deadlock_err_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign deadlock_err = deadlock_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver pushes hand-computed expectations
// per cycle, the monitor pops and compares them on the falling edge.
module tb_hazard_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt, id_branch;
    logic        ex_memread, ex_regwrite;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;
    logic        hazard, BranchBubble, idex_flush;
    logic [31:0] stall_cnt;
    logic        deadlock_err;

    typedef struct {
        string       name;
        logic        hz;
        logic        bb;
        logic        fl;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_unit #(.WDOG_LIMIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_branch    (id_branch),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .mem_memread  (mem_memread),
        .mem_rd       (mem_rd),
        .hazard       (hazard),
        .BranchBubble (BranchBubble),
        .idex_flush   (idex_flush),
        .stall_cnt    (stall_cnt),
        .deadlock_err (deadlock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare current-cycle outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (hazard !== e.hz || BranchBubble !== e.bb || idex_flush !== e.fl ||
                stall_cnt !== e.cnt || deadlock_err !== e.err || (hazard && BranchBubble)) begin
                errors++;
                $display("FAIL %s: got hz=%0b bb=%0b fl=%0b cnt=%h err=%0b, expected hz=%0b bb=%0b fl=%0b cnt=%h err=%0b",
                         e.name, hazard, BranchBubble, idex_flush, stall_cnt, deadlock_err,
                         e.hz, e.bb, e.fl, e.cnt, e.err);
            end
        end
    end

    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_branch = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        mem_memread = 1'b0; mem_rd = 5'd0;
    endtask

    // Branch whose rt operand is being loaded by the instruction in EX.
    task automatic br_load_pattern();
        quiet();
        id_branch = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
    endtask

    task automatic load_use_pattern();
        quiet();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic hz, input logic bb, input logic fl,
                       input logic [31:0] cnt, input logic err);
        exp_t e;
        e.name = nm; e.hz = hz; e.bb = bb; e.fl = fl; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        load_use_pattern();
        @(posedge clk);
        #1;
        // Reset holds stall outputs low even with a load-use pattern present.
        cyc("reset_gate", 0, 0, 0, 32'd0, 0);
        rst = 1'b0;

        // r0 never stalls, in EX or in MEM.
        quiet(); ex_memread = 1'b1; id_use_rs = 1'b1;
        cyc("zero_ex", 0, 0, 0, 32'd0, 0);
        quiet(); id_branch = 1'b1; mem_memread = 1'b1; id_use_rt = 1'b1;
        cyc("zero_mem", 0, 0, 0, 32'd0, 0);

        // Load-use: a single freeze cycle, then LD_STALL is silent.
        load_use_pattern();
        cyc("ldu_c0", 1, 0, 1, 32'd0, 0);
        cyc("ldu_c1", 0, 0, 0, 32'd1, 0);
        quiet();
        cyc("ldu_q", 0, 0, 0, 32'd1, 0);

        // Branch on EX load: hazard, hazard, bubble.
        br_load_pattern();
        cyc("brld_c0", 1, 0, 1, 32'd1, 0);
        cyc("brld_c1", 1, 0, 1, 32'd2, 0);
        cyc("brld_c2", 0, 1, 1, 32'd3, 0);
        quiet();
        cyc("brld_q", 0, 0, 0, 32'd4, 0);

        // Branch on ALU result: bubble from IDLE, then BR_WAIT1 bubbles too; no hazard.
        quiet(); id_branch = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
        cyc("bralu_c0", 0, 1, 1, 32'd4, 0);
        quiet();
        cyc("bralu_c1", 0, 1, 1, 32'd5, 0);
        cyc("bralu_q", 0, 0, 0, 32'd6, 0);

        // Branch on a load sitting in MEM.
        quiet(); id_branch = 1'b1; mem_memread = 1'b1; mem_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
        cyc("brmem_c0", 0, 1, 1, 32'd6, 0);
        quiet();
        cyc("brmem_c1", 0, 1, 1, 32'd7, 0);
        cyc("brmem_q", 0, 0, 0, 32'd8, 0);

        // All conditions at once: branch-on-EX-load wins.
        quiet(); id_branch = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
        mem_memread = 1'b1; mem_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        cyc("prio_c0", 1, 0, 1, 32'd8, 0);
        cyc("prio_c1", 1, 0, 1, 32'd9, 0);
        cyc("prio_c2", 0, 1, 1, 32'd10, 0);
        quiet();
        cyc("prio_q", 0, 0, 0, 32'd11, 0);

        // Register not actually read, and ALU producer without a branch: no stall.
        load_use_pattern(); id_use_rs = 1'b0;
        cyc("unused_rs", 0, 0, 0, 32'd11, 0);
        quiet(); ex_regwrite = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
        cyc("alu_nobr", 0, 0, 0, 32'd11, 0);

        // Reset in cycle 1 of the branch-on-load sequence aborts it.
        br_load_pattern();
        cyc("rmid_c0", 1, 0, 1, 32'd11, 0);
        rst = 1'b1;
        cyc("rmid_rst", 0, 0, 0, 32'd12, 0);
        rst = 1'b0;
        quiet();
        cyc("rmid_after", 0, 0, 0, 32'd0, 0);

        // Back-to-back branch-on-load chains: 15 consecutive stalls trip the watchdog.
        br_load_pattern();
        for (int k = 0; k < 18; k++) begin
            cyc($sformatf("wdog_%0d", k), (k % 3) != 2, (k % 3) == 2, 1'b1, 32'(k), k >= 15);
        end
        quiet();
        cyc("wdog_q0", 0, 0, 0, 32'd18, 1);
        cyc("wdog_q1", 0, 0, 0, 32'd18, 1);

        // Preload the total near its top and let a stall chain wrap it.
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        br_load_pattern();
        cyc("wrap_c0", 1, 0, 1, 32'hFFFF_FFFE, 1);
        cyc("wrap_c1", 1, 0, 1, 32'hFFFF_FFFF, 1);
        cyc("wrap_c2", 0, 1, 1, 32'h0000_0000, 1);
        quiet();
        cyc("wrap_q", 0, 0, 0, 32'd1, 1);

        // Only reset clears the sticky watchdog.
        rst = 1'b1;
        cyc("wdog_rst", 0, 0, 0, 32'd1, 1);
        rst = 1'b0;
        cyc("wdog_clr", 0, 0, 0, 32'd0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
